// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-stage controller of the 5-stage MIPS pipeline.
//
// This module decodes the M-stage instruction held in the E/M register.
// For a load or store it issues one valid/ready data-memory request.
// It stalls the upstream stages until the access completes, then extends
// the load data and registers the result into the W stage.
//
// Handshake semantics: a request transfers on a clk edge where
// dm_req_valid && dm_req_ready. Once dm_req_valid is raised, it stays
// asserted with stable address, enables and data (the E/M register is
// held by m_stall) until the transfer. A load response is accepted only
// on an edge where the controller is in WAIT and dm_rsp_valid is high.
//
// Parameters:
//   RSP_TIMEOUT  maximum WAIT cycles before w_err is flagged; 0 = no timeout
//
// Optional build macro:
//   MEM_ALIGN_CHECK_EN  when this macro is defined, misaligned lw/lh/lhu/sw/sh
//                       accesses issue no request. They complete in W with
//                       w_adel_ades=1.
//
// Ports:
//   clk, rst                 clock; synchronous active-low reset
//   m_valid, M_PC, M_IR,     M-stage fields from the E/M register
//   M_ALUO, M_PC8, M_rt
//   m_stall                  hold F/D/E/M this cycle (combinational)
//   dm_req_valid/ready       data-memory request handshake
//   dm_addr, dm_we, dm_be,   word address, write flag, byte enables,
//   dm_wdata                 lane-replicated store data
//   dm_rsp_valid, dm_rdata   load response
//   W_PC, W_IR, W_ALUO,      registered W-stage copies
//   W_PC8, W_DR
//   w_valid, w_err           W holds a real instruction / response timed out
//   w_adel_ades              (MEM_ALIGN_CHECK_EN only) address error
//   state_dbg                current FSM state (0 = IDLE, 1 = WAIT)

module mem_stage_ctrl #(
   parameter int RSP_TIMEOUT = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m_valid,
   input  logic [31:0] M_PC,
   input  logic [31:0] M_IR,
   input  logic [31:0] M_ALUO,
   input  logic [31:0] M_PC8,
   input  logic [31:0] M_rt,
   output logic        m_stall,
   output logic        dm_req_valid,
   input  logic        dm_req_ready,
   output logic [31:0] dm_addr,
   output logic        dm_we,
   output logic [3:0]  dm_be,
   output logic [31:0] dm_wdata,
   input  logic        dm_rsp_valid,
   input  logic [31:0] dm_rdata,
   output logic [31:0] W_PC,
   output logic [31:0] W_IR,
   output logic [31:0] W_ALUO,
   output logic [31:0] W_PC8,
   output logic [31:0] W_DR,
   output logic        w_valid,
   output logic        w_err,
`ifdef MEM_ALIGN_CHECK_EN
   output logic        w_adel_ades,
`endif
   output logic [0:0]  state_dbg
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] WAIT = 1'b1;

   logic [0:0]  state;
   logic [15:0] cnt;
   logic [2:0]  ld_op;    // opcode[2:0]: bit2 = unsigned, bits1:0 = size
   logic [1:0]  ld_off;

   logic [5:0]  op;
   logic        is_load, is_store, misaligned, mem_load, mem_store;
   logic        timeout_hit;
   logic        cap, cap_valid, cap_err, cap_adel;
   logic [31:0] cap_dr, ext;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   assign op = M_IR[31:26];

   assign is_load  = m_valid && (op == 6'h20 || op == 6'h21 || op == 6'h23 ||
                                 op == 6'h24 || op == 6'h25);
   assign is_store = m_valid && (op == 6'h28 || op == 6'h29 || op == 6'h2B);

`ifdef MEM_ALIGN_CHECK_EN
   // op[1:0]==11 is a word access, 01 is a halfword access
   assign misaligned = (is_load || is_store) &&
                       ((op[1:0] == 2'b11 && M_ALUO[1:0] != 2'b00) ||
                        (op[1:0] == 2'b01 && M_ALUO[0]));
`else
   assign misaligned = 1'b0;
`endif

   assign mem_load  = is_load  && !misaligned;
   assign mem_store = is_store && !misaligned;

   // Request side: the address, enables and data always follow the M fields.
   // Only dm_req_valid qualifies them.
   assign dm_req_valid = rst && (state == IDLE) && (mem_load || mem_store);
   assign dm_addr      = {M_ALUO[31:2], 2'b00};
   assign dm_we        = mem_store;

   always_comb begin
      dm_be    = 4'b1111;
      dm_wdata = M_rt;
      case (op[1:0])
         2'b00: begin
            dm_be    = 4'b0001 << M_ALUO[1:0];
            dm_wdata = {4{M_rt[7:0]}};
         end
         2'b01: begin
            dm_be    = M_ALUO[1] ? 4'b1100 : 4'b0011;
            dm_wdata = {2{M_rt[15:0]}};
         end
         default: begin
            dm_be    = 4'b1111;
            dm_wdata = M_rt;
         end
      endcase
   end

   // The timeout fires on the edge that ends the RSP_TIMEOUT-th WAIT cycle
   // without a response. A response on that same edge takes priority.
   assign timeout_hit = (RSP_TIMEOUT != 0) && (state == WAIT) && !dm_rsp_valid &&
                        ({16'd0, cnt} == 32'(RSP_TIMEOUT - 1));

   // The timeout edge also completes the instruction, so E/M must advance.
   always_comb begin
      m_stall = 1'b0;
      if (state == WAIT)
         m_stall = !(dm_rsp_valid || timeout_hit);
      else if (mem_load)
         m_stall = 1'b1;
      else if (mem_store)
         m_stall = !dm_req_ready;
   end

   // Load data extraction uses the type and offset latched at the request.
   always_comb begin
      lane_b = 8'h00;
      case (ld_off)
         2'd0: lane_b = dm_rdata[7:0];
         2'd1: lane_b = dm_rdata[15:8];
         2'd2: lane_b = dm_rdata[23:16];
         default: lane_b = dm_rdata[31:24];
      endcase
      lane_h = ld_off[1] ? dm_rdata[31:16] : dm_rdata[15:0];
      ext    = dm_rdata;
      case (ld_op[1:0])
         2'b00:   ext = ld_op[2] ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
         2'b01:   ext = ld_op[2] ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
         default: ext = dm_rdata;
      endcase
   end

   // W capture decision for this cycle
   always_comb begin
      cap       = 1'b0;
      cap_valid = 1'b0;
      cap_dr    = 32'h0;
      cap_err   = 1'b0;
      cap_adel  = 1'b0;
      if (state == WAIT) begin
         if (dm_rsp_valid) begin
            cap       = 1'b1;
            cap_valid = 1'b1;
            cap_dr    = ext;
         end else if (timeout_hit) begin
            cap       = 1'b1;
            cap_valid = 1'b1;
            cap_err   = 1'b1;
         end
      end else if (mem_store) begin
         cap       = dm_req_ready;
         cap_valid = 1'b1;
      end else if (!mem_load) begin
         // Non-memory ops and bubbles pass straight through.
         // A misaligned access completes here with its error flag set.
         cap       = 1'b1;
         cap_valid = m_valid;
         cap_adel  = misaligned;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= 16'd0;
         ld_op   <= 3'd0;
         ld_off  <= 2'd0;
         W_PC    <= 32'h0;
         W_IR    <= 32'h0;
         W_ALUO  <= 32'h0;
         W_PC8   <= 32'h0;
         W_DR    <= 32'h0;
         w_valid <= 1'b0;
         w_err   <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
         w_adel_ades <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (mem_load && dm_req_ready) begin
                  state  <= WAIT;
                  cnt    <= 16'd0;
                  ld_op  <= op[2:0];
                  ld_off <= M_ALUO[1:0];
               end
            end
            default: begin
               if (cap) state <= IDLE;
               else     cnt   <= cnt + 16'd1;
            end
         endcase

         if (cap) begin
            W_PC   <= M_PC;
            W_IR   <= M_IR;
            W_ALUO <= M_ALUO;
            W_PC8  <= M_PC8;
            W_DR   <= cap_dr;
            w_err  <= cap_err;
`ifdef MEM_ALIGN_CHECK_EN
            w_adel_ades <= cap_adel;
`endif
         end
         // A bubble goes into W on any cycle where nothing completes.
         w_valid <= cap && cap_valid;
      end
   end

`ifndef MEM_ALIGN_CHECK_EN
   logic unused_adel;
   assign unused_adel = cap_adel;
`endif

   assign state_dbg = state;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl.
// The DUT is built with RSP_TIMEOUT=4.
// Inputs are driven 1 time unit after the rising edge.
// Outputs are sampled 1 further unit later, well clear of the next edge.

module tb_mem_stage_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        m_valid;
   logic [31:0] M_PC, M_IR, M_ALUO, M_PC8, M_rt;
   logic        m_stall;
   logic        dm_req_valid, dm_req_ready;
   logic [31:0] dm_addr;
   logic        dm_we;
   logic [3:0]  dm_be;
   logic [31:0] dm_wdata;
   logic        dm_rsp_valid;
   logic [31:0] dm_rdata;
   logic [31:0] W_PC, W_IR, W_ALUO, W_PC8, W_DR;
   logic        w_valid, w_err;
`ifdef MEM_ALIGN_CHECK_EN
   logic        w_adel_ades;
`endif
   logic [0:0]  state_dbg;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];

   // clock / reset
   always #5 clk = ~clk;

   mem_stage_ctrl #(.RSP_TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .m_valid(m_valid),
      .M_PC(M_PC), .M_IR(M_IR), .M_ALUO(M_ALUO), .M_PC8(M_PC8), .M_rt(M_rt),
      .m_stall(m_stall),
      .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready),
      .dm_addr(dm_addr), .dm_we(dm_we), .dm_be(dm_be), .dm_wdata(dm_wdata),
      .dm_rsp_valid(dm_rsp_valid), .dm_rdata(dm_rdata),
      .W_PC(W_PC), .W_IR(W_IR), .W_ALUO(W_ALUO), .W_PC8(W_PC8), .W_DR(W_DR),
      .w_valid(w_valid), .w_err(w_err),
`ifdef MEM_ALIGN_CHECK_EN
      .w_adel_ades(w_adel_ades),
`endif
      .state_dbg(state_dbg)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // advance to just after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ir,
                        input logic [31:0] aluo, input logic [31:0] rt);
      m_valid = v;
      M_PC    = pc;
      M_IR    = ir;
      M_ALUO  = aluo;
      M_PC8   = pc + 32'd8;
      M_rt    = rt;
   endtask

   localparam logic [31:0] IR_ADDU = 32'h0000_0021;
   localparam logic [31:0] IR_LB   = 32'h8000_0000;
   localparam logic [31:0] IR_LH   = 32'h8400_0000;
   localparam logic [31:0] IR_LW   = 32'h8C00_0000;
   localparam logic [31:0] IR_LHU  = 32'h9400_0000;
   localparam logic [31:0] IR_SB   = 32'hA000_0000;
   localparam logic [31:0] IR_SH   = 32'hA400_0000;
   localparam logic [31:0] IR_SW   = 32'hAC00_0000;

   initial begin
      rst = 1'b0;
      dm_req_ready = 1'b0;
      dm_rsp_valid = 1'b0;
      dm_rdata = 32'h0;
      drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);

      // reset
      step(); step();
      check("rst_w_pc", W_PC, 32'h0);
      check("rst_w_valid", {31'b0, w_valid}, 32'h0);
      check("rst_w_err", {31'b0, w_err}, 32'h0);
      check("rst_req_valid", {31'b0, dm_req_valid}, 32'h0);
      check("rst_state", {31'b0, state_dbg}, 32'h0);

      // non-memory addu
      rst = 1'b1;
      drive(1'b1, 32'h3000, IR_ADDU, 32'h1234, 32'h0);
      #1;
      check("addu_stall", {31'b0, m_stall}, 32'h0);
      check("addu_req", {31'b0, dm_req_valid}, 32'h0);
      step();
      check("addu_w_pc", W_PC, 32'h3000);
      check("addu_w_valid", {31'b0, w_valid}, 32'h1);
      check("addu_w_dr", W_DR, 32'h0);
      check("addu_w_aluo", W_ALUO, 32'h1234);
      check("addu_w_pc8", W_PC8, 32'h3008);
      check("addu_w_ir", W_IR, IR_ADDU);

      // sb with ready low for 2 cycles
      drive(1'b1, 32'h3004, IR_SB, 32'h13, 32'hA5);
      dm_req_ready = 1'b0;
      #1;
      check("sb_req_valid", {31'b0, dm_req_valid}, 32'h1);
      check("sb_stall0", {31'b0, m_stall}, 32'h1);
      check("sb_be", {28'b0, dm_be}, 32'h8);
      check("sb_wdata", dm_wdata, 32'hA5A5A5A5);
      check("sb_addr", dm_addr, 32'h10);
      check("sb_we", {31'b0, dm_we}, 32'h1);
      step();
      check("sb_bubble", {31'b0, w_valid}, 32'h0);
      check("sb_w_hold", W_PC, 32'h3000);
      check("sb_stall1", {31'b0, m_stall}, 32'h1);
      step();
      dm_req_ready = 1'b1;
      #1;
      check("sb_stall_rdy", {31'b0, m_stall}, 32'h0);
      step();
      check("sb_w_pc", W_PC, 32'h3004);
      check("sb_w_valid", {31'b0, w_valid}, 32'h1);
      check("sb_state", {31'b0, state_dbg}, 32'h0);

      // lb at 0x22; a response in the request cycle must be ignored
      drive(1'b1, 32'h3008, IR_LB, 32'h22, 32'h0);
      dm_rsp_valid = 1'b1;
      dm_rdata = 32'hDEAD_BEEF;
      exp_q.push_back(32'hFFFF_FF80);
      #1;
      check("lb_stall", {31'b0, m_stall}, 32'h1);
      check("lb_we", {31'b0, dm_we}, 32'h0);
      check("lb_addr", dm_addr, 32'h20);
      step();
      dm_rsp_valid = 1'b0;
      #1;
      check("lb_state_wait", {31'b0, state_dbg}, 32'h1);
      check("lb_no_early", {31'b0, w_valid}, 32'h0);
      check("lb_wait_req", {31'b0, dm_req_valid}, 32'h0);
      check("lb_wait_stall", {31'b0, m_stall}, 32'h1);
      step();
      step();
      dm_rsp_valid = 1'b1;
      dm_rdata = 32'h1280_7F00;
      #1;
      check("lb_rsp_stall", {31'b0, m_stall}, 32'h0);
      step();
      dm_rsp_valid = 1'b0;
      check("lb_w_dr", W_DR, exp_q.pop_front());
      check("lb_w_valid", {31'b0, w_valid}, 32'h1);
      check("lb_w_pc", W_PC, 32'h3008);
      check("lb_w_err", {31'b0, w_err}, 32'h0);

      // lhu at 0x22, minimum latency
      drive(1'b1, 32'h300C, IR_LHU, 32'h22, 32'h0);
      exp_q.push_back(32'h0000_1280);
      step();
      dm_rsp_valid = 1'b1;
      step();
      dm_rsp_valid = 1'b0;
      check("lhu_w_dr", W_DR, exp_q.pop_front());
      check("lhu_w_valid", {31'b0, w_valid}, 32'h1);

      // reset while in WAIT, then a stray response
      drive(1'b1, 32'h3010, IR_LW, 32'h40, 32'h0);
      step();
      check("rw_state", {31'b0, state_dbg}, 32'h1);
      rst = 1'b0;
      step();
      check("rw_w_pc", W_PC, 32'h0);
      check("rw_w_dr", W_DR, 32'h0);
      check("rw_w_valid", {31'b0, w_valid}, 32'h0);
      check("rw_state_idle", {31'b0, state_dbg}, 32'h0);
      rst = 1'b1;
      drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      dm_rsp_valid = 1'b1;
      dm_rdata = 32'hFFFF_FFFF;
      #1;
      check("rw_stray_stall", {31'b0, m_stall}, 32'h0);
      step();
      dm_rsp_valid = 1'b0;
      check("rw_stray_valid", {31'b0, w_valid}, 32'h0);
      check("rw_stray_dr", W_DR, 32'h0);
      check("rw_stray_state", {31'b0, state_dbg}, 32'h0);

      // timeout: lw with no response for 4 WAIT cycles
      drive(1'b1, 32'h3014, IR_LW, 32'h44, 32'h0);
      step();
      for (int i = 0; i < 4; i++) begin
         check("to_state_wait", {31'b0, state_dbg}, 32'h1);
         check("to_no_done", {31'b0, w_valid}, 32'h0);
         if (i < 3) check("to_stall", {31'b0, m_stall}, 32'h1);
         step();
      end
      check("to_w_err", {31'b0, w_err}, 32'h1);
      check("to_w_dr", W_DR, 32'h0);
      check("to_w_valid", {31'b0, w_valid}, 32'h1);
      check("to_w_pc", W_PC, 32'h3014);
      check("to_state", {31'b0, state_dbg}, 32'h0);
      drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      dm_rsp_valid = 1'b1;
      step();
      dm_rsp_valid = 1'b0;
      check("to_late_valid", {31'b0, w_valid}, 32'h0);
      check("to_late_state", {31'b0, state_dbg}, 32'h0);

`ifdef MEM_ALIGN_CHECK_EN
      // misaligned lw raises an address error without a request
      drive(1'b1, 32'h3018, IR_LW, 32'h102, 32'h0);
      #1;
      check("al_req", {31'b0, dm_req_valid}, 32'h0);
      check("al_stall", {31'b0, m_stall}, 32'h0);
      step();
      check("al_adel", {31'b0, w_adel_ades}, 32'h1);
      check("al_w_valid", {31'b0, w_valid}, 32'h1);
      check("al_w_dr", W_DR, 32'h0);
      drive(1'b1, 32'h301C, IR_ADDU, 32'h0, 32'h0);
      step();
      check("al_adel_clr", {31'b0, w_adel_ades}, 32'h0);
`else
      // sh at odd address: addr[0] ignored, upper half selected
      drive(1'b1, 32'h3018, IR_SH, 32'h23, 32'h1234_BEEF);
      #1;
      check("sh_be", {28'b0, dm_be}, 32'hC);
      check("sh_wdata", dm_wdata, 32'hBEEF_BEEF);
      check("sh_addr", dm_addr, 32'h20);
      step();
      // sw with low address bits ignored
      drive(1'b1, 32'h301C, IR_SW, 32'h103, 32'h0BAD_F00D);
      #1;
      check("sw_be", {28'b0, dm_be}, 32'hF);
      check("sw_wdata", dm_wdata, 32'h0BAD_F00D);
      check("sw_addr", dm_addr, 32'h100);
      step();
      // lh sign extension at lane 0 with addr[0] set
      drive(1'b1, 32'h3020, IR_LH, 32'h21, 32'h0);
      exp_q.push_back(32'hFFFF_F00D);
      step();
      dm_rsp_valid = 1'b1;
      dm_rdata = 32'h1234_F00D;
      step();
      dm_rsp_valid = 1'b0;
      check("lh_w_dr", W_DR, exp_q.pop_front());
      // lw at misaligned address returns the whole word
      drive(1'b1, 32'h3024, IR_LW, 32'h47, 32'h0);
      exp_q.push_back(32'h8765_4321);
      step();
      dm_rsp_valid = 1'b1;
      dm_rdata = 32'h8765_4321;
      step();
      dm_rsp_valid = 1'b0;
      check("lw_w_dr", W_DR, exp_q.pop_front());
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-stage controller of the 5-stage MIPS pipeline.
- Consumes the M-stage fields held by the E/M pipeline register and issues a valid/ready data-memory request when the instruction is a load or store.
- Stalls the upstream stages until the access completes, extracts and extends load data, and registers the result into the W stage.

Parameters:
- RSP_TIMEOUT, 0: maximum WAIT cycles before an error is flagged; 0 disables the timeout.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-low
- m_valid  input  1  M stage holds a real instruction (0 = bubble)
- M_PC  input  32  PC of the M-stage instruction
- M_IR  input  32  instruction word
- M_ALUO  input  32  ALU result; effective address for loads/stores
- M_PC8  input  32  PC+8, link value
- M_rt  input  32  store data
- m_stall  output  1  hold the F/D/E/M registers this cycle (combinational)
- dm_req_valid  output  1  memory request valid
- dm_req_ready  input  1  memory accepts the request
- dm_addr  output  32  word address, {M_ALUO[31:2],2'b00}
- dm_we  output  1  1 = store
- dm_be  output  4  byte enables
- dm_wdata  output  32  store data, lane-replicated
- dm_rsp_valid  input  1  load data valid
- dm_rdata  input  32  load data word
- W_PC, W_IR, W_ALUO, W_PC8  output  32 each  registered copies of the M fields
- W_DR  output  32  extended load data; 0 for non-loads
- w_valid  output  1  W stage holds a real instruction
- w_err  output  1  response timeout occurred for this instruction

Behaviour:
- Opcode decode from M_IR[31:26]:
  - Loads: lb 0x20, lh 0x21, lw 0x23, lbu 0x24, lhu 0x25.
  - Stores: sb 0x28, sh 0x29, sw 0x2B.
  - All other opcodes, or m_valid=0: non-memory.
- Reset (rst=0 at a clk edge):
  - State goes to IDLE; timeout counter cleared.
  - All W_* outputs, w_valid and w_err become 0.
  - dm_req_valid=0 during reset cycles.
  - A reset in WAIT abandons the access; a later dm_rsp_valid in IDLE is ignored.
- States: IDLE, WAIT.
- IDLE, non-memory instruction:
  - m_stall=0; W captures the M fields at the next edge; W_DR=0; w_valid=m_valid. Latency 1.
- IDLE, memory instruction:
  - dm_req_valid=1, driven combinationally from the M fields.
  - Store: m_stall = ~dm_req_ready. On the handshake, W captures and w_valid=1; state stays IDLE.
  - Load: m_stall=1. On the handshake, latch the load type and ALUO[1:0], then go to WAIT.
- WAIT:
  - dm_req_valid=0; m_stall = ~dm_rsp_valid.
  - On dm_rsp_valid: W captures with the extended W_DR, w_valid=1, next state IDLE. The E/M register advances at the same edge.
  - Minimum load latency is 2 cycles.
  - A response arriving in the same cycle as the request is not accepted.
- Store lane rules:
  - sw: be=1111, wdata=rt.
  - sh: be = addr[1] ? 1100 : 0011; wdata={rt[15:0],rt[15:0]}.
  - sb: be = 0001 << addr[1:0]; wdata=rt[7:0] replicated 4x.
- Load extract:
  - lb/lbu: byte at lane addr[1:0], sign- or zero-extended.
  - lh/lhu: halfword at addr[1], sign- or zero-extended.
  - lw: the full word.
- Misalignment (macro absent): halfword accesses ignore addr[0]; word accesses ignore addr[1:0].
- Timeout (RSP_TIMEOUT>0):
  - The counter increments in each WAIT cycle without a response.
  - When it reaches RSP_TIMEOUT: W captures with W_DR=0, w_err=1, next state IDLE.
  - A response arriving at the same edge wins (w_err=0). Later stray responses are ignored in IDLE.
- While W is not capturing and not in reset, the W registers hold their values.
  - Exception: w_valid is 0 after any cycle where nothing completed (bubble insertion during stall).

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - Adds output port w_adel_ades (1 bit).
  - Misaligned accesses (lw/sw with addr[1:0]≠0; lh/lhu/sh with addr[0]=1) issue no request and cause no stall.
  - W captures next edge with W_DR=0, w_valid=1, w_adel_ades=1.
  - w_adel_ades resets to 0 and is 0 for all other instructions.
- Absent: no extra port; misalignment is handled by the ignore-bits rule above.

Test Plan:
- Reset released, non-memory addu with M_PC=0x3000 -> next edge: W_PC=0x3000, w_valid=1, W_DR=0, m_stall never 1.
- sb with ALUO=0x0000_0013, rt=0x0000_00A5, dm_req_ready low for 2 cycles then high:
  - m_stall=1 for 2 cycles; dm_be=1000, dm_wdata=0xA5A5A5A5, dm_addr=0x10.
  - W updated at the handshake edge.
- lb with ALUO=0x22, rdata=0x1280_7F00, response 3 cycles after the request -> W_DR=0xFFFF_FF80, w_valid=1. Then lhu at ALUO=0x22 with the same rdata -> W_DR=0x0000_1280.
- Load in WAIT, rst=0 for 1 cycle, stray dm_rsp_valid next cycle -> all W outputs 0, state IDLE, stray response ignored, m_stall=0.
- RSP_TIMEOUT=4, lw with no response -> 4 WAIT cycles, then w_err=1, W_DR=0; a late response is ignored.
- MEM_ALIGN_CHECK_EN defined, lw at ALUO=0x0000_0102 -> dm_req_valid stays 0, m_stall=0, next edge w_adel_ades=1.
